// File: rtl/instr_encoder_fifo.sv
// Packs decoded instruction field tuples into 32-bit words and buffers them in a
// small FIFO with valid/ready handshakes on both sides.
module instr_encoder_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter logic [3:0]  COND  = 4'b1110
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 ins_type,
  input  logic [2:0]                 data_ins_type,
  input  logic [1:0]                 mem_ins_type,
  input  logic [1:0]                 branch_ins_type,
  input  logic [3:0]                 rn,
  input  logic [3:0]                 rd,
  input  logic [23:0]                imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                instruction,
  output logic                       err_pulse,
  output logic [15:0]                enc_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [1:0] TYPE_DATA   = 2'b00;
  localparam logic [1:0] TYPE_MEM    = 2'b01;
  localparam logic [1:0] TYPE_BRANCH = 2'b10;
  localparam logic [1:0] TYPE_RSVD   = 2'b11;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_next;
  logic [31:0]   enc_word;
  logic          accept;
  logic          push;
  logic          pop;

  // Occupancy-derived handshake flags; depend on state only, never on out_ready.
  assign in_ready    = (fifo_level != LW'(DEPTH));
  assign out_valid   = (fifo_level != '0);
  assign accept      = in_valid && in_ready;
  assign push        = accept && (ins_type != TYPE_RSVD);
  assign pop         = out_valid && out_ready;
  assign rd_ptr_next = rd_ptr + AW'(1);

  // Field packing; every bit not owned by the selected format stays zero.
  always_comb begin
    enc_word        = '0;
    enc_word[31:28] = COND;
    enc_word[27:26] = ins_type;
    case (ins_type)
      TYPE_DATA: begin
        enc_word[23:21] = data_ins_type;
        enc_word[19:16] = rn;
        enc_word[15:12] = rd;
        enc_word[11:0]  = imm[11:0];
      end
      TYPE_MEM: begin
        enc_word[21:20] = mem_ins_type;
        enc_word[19:16] = rn;
        enc_word[15:12] = rd;
        enc_word[11:0]  = imm[11:0];
      end
      TYPE_BRANCH: begin
        enc_word[25:24] = branch_ins_type;
        enc_word[23:0]  = imm;
      end
      default: ;
    endcase
  end

  // Storage array; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  // Pointers, occupancy, registered head word, error flag and pop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      instruction <= '0;
      err_pulse   <= 1'b0;
      enc_count   <= '0;
    end else begin
      err_pulse <= accept && (ins_type == TYPE_RSVD);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr_next;
        enc_count <= enc_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase
      // Head register: next stored entry, or the word entering an (about to be) empty FIFO.
      if (pop) begin
        if (fifo_level > LW'(1)) begin
          instruction <= mem[rd_ptr_next];
        end else if (push) begin
          instruction <= enc_word;
        end
      end else if (push && (fifo_level == '0)) begin
        instruction <= enc_word;
      end
    end
  end

endmodule

// File: doc/instr_encoder_fifo.md
Name: instr_encoder_fifo

Overview:
- Encoder for the team's 32-bit instruction format; the write side of the instruction decoder.
- Accepts decoded field tuples (type, sub-type, registers, immediate) over a valid/ready handshake and packs each into a 32-bit instruction word.
- Encoded words are buffered in a small FIFO and emitted over a second valid/ready handshake.
- Feeds the decoder and instruction memory loaders in the lab datapath; also used by benches to generate legal stimulus.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- COND, 4'b1110, constant condition field written to bits [31:28].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  field tuple valid.
- in_ready  output  1  encoder can accept a tuple.
- ins_type  input  2  00 data, 01 memory, 10 branch, 11 reserved.
- data_ins_type  input  3  data-processing sub-op.
- mem_ins_type  input  2  memory sub-op.
- branch_ins_type  input  2  branch sub-op.
- rn  input  4  base/first source register.
- rd  input  4  destination register.
- imm  input  24  immediate/offset; low 12 bits for data/mem, all 24 bits for branch.
- out_valid  output  1  instruction word valid.
- out_ready  input  1  consumer accepts the word.
- instruction  output  32  encoded word (FIFO head).
- err_pulse  output  1  one-cycle flag: reserved type accepted.
- enc_count  output  16  count of words emitted.
- fifo_level  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst_n=0): FIFO empty; pointers 0; out_valid=0; instruction=0; err_pulse=0; enc_count=0; fifo_level=0; in_ready=1 after release.
- Encoding (combinational on inputs; captured at accept): [31:28]=COND and [27:26]=ins_type for every type.
  - Data: [25:24]=00; [23:21]=data_ins_type; [20]=0; [19:16]=rn; [15:12]=rd; [11:0]=imm[11:0].
  - Memory: [25:22]=0000; [21:20]=mem_ins_type; [19:16]=rn; [15:12]=rd; [11:0]=imm[11:0].
  - Branch: [25:24]=branch_ins_type; [23:0]=imm; rn and rd ignored.
  - Unused input bits are ignored and never leak into the word.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = (fifo_level != DEPTH). in_ready is combinational on state only, never on out_ready.
- Push: an accepted legal tuple writes one entry.
- Reserved type: an accepted ins_type=11 completes the handshake and writes nothing. err_pulse goes high for exactly the next cycle; FIFO state and enc_count are unchanged.
- Latency: a tuple accepted at edge N into an empty FIFO gives out_valid=1 and a valid instruction after edge N. There is no same-cycle bypass.
- Pop: out_valid && out_ready at an edge. instruction always reflects the head entry; it is held stable while out_valid=1 && out_ready=0.
- Simultaneous push and pop: both occur; fifo_level is unchanged; order is preserved.
- Full: in_ready=0; in_valid is ignored (no write, no error). If a pop occurs in that cycle, in_ready rises the next cycle.
- Empty: out_valid=0; out_ready is ignored; instruction holds its last value (0 after reset).
- Pointers wrap modulo DEPTH. fifo_level is tracked exactly, from 0 to DEPTH.
- enc_count increments on each pop and wraps 16'hFFFF -> 0.
- Reset mid-operation: all buffered words are discarded immediately; no partial word is ever emitted.

Test Plan:
- Data encode: after reset, push {00, data=010, rn=1, rd=2, imm=0x000005} with out_ready=1 -> out_valid 1 cycle later, instruction=0xE0412005, enc_count=1.
- Memory and branch: push {01, mem=01, rn=3, rd=4, imm=0x010}, then {10, br=01, imm=0x000100} -> words 0xE4134010 then 0xE9000100, in order.
- Backpressure/full: out_ready=0, push 5 legal tuples with DEPTH=4 -> in_ready=0 after the 4th, fifo_level=4, 5th not accepted. Raise out_ready -> 4 words drain in order; in_ready returns the cycle after the first pop.
- Reserved: push ins_type=11 -> err_pulse=1 for exactly one cycle; fifo_level and enc_count unchanged; out_valid stays 0.
- Simultaneous: FIFO at level 2, push and pop in the same cycle -> level stays 2; the popped word is the oldest entry.
- Async reset: assert rst_n=0 mid-cycle with 3 entries buffered -> out_valid, fifo_level, and enc_count are 0 immediately, without waiting for a clock edge.
